// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolution slice.
package branch_pkg;

    // Default PC width used by the default queue entry type.
    localparam int unsigned BR_XLEN = 32;

    // One in-flight predicted branch: direction, instruction PC, predicted target.
    typedef struct packed {
        logic               taken;
        logic [BR_XLEN-1:0] pc;
        logic [BR_XLEN-1:0] target;
    } br_entry_t;

    // Queue index width, excluding the extra wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Increment that holds at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
        logic [63:0] max_val;
        max_val = (64'd1 << width) - 64'd1;
        return (value >= max_val) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/branch_queue.sv
// In-order FIFO of in-flight predicted branches; clear wins over push.
module branch_queue
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = br_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    input  logic   clear_i,
    output logic   full_o,
    output logic   empty_o,
    output entry_t head_o
);

    localparam int unsigned AW      = ptr_w(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    entry_t      mem_q [DEPTH];
    logic        do_write;

    // Same index with different wrap bits means the writer is a full lap ahead.
    assign empty_o  = (wr_q == rd_q);
    assign full_o   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o   = mem_q[rd_q[AW-1:0]];
    assign do_write = push_i && !full_o && !clear_i;

    // Pointer next-state: clear resets both, otherwise push/pop advance independently.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clear_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_write) begin
                wr_d = wr_q + PTR_ONE;
            end
            if (pop_i && !empty_o) begin
                rd_d = rd_q + PTR_ONE;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Entry storage; contents are only meaningful between rd and wr.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Checks queued fetch-stage predictions against EX outcomes; drives flush,
// redirect, predictor training pulses and statistics.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pred_valid,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_pc,
    input  logic [XLEN-1:0]  pred_target,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [XLEN-1:0]  res_target,
    output logic             upd_valid,
    output logic             upd_taken,
    output logic             flush,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count,
    output logic             res_error
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } entry_t;

    entry_t push_entry;
    entry_t head;
    logic   q_full, q_empty;
    logic   do_push, do_pop, mis, drop;

    logic             upd_valid_q, upd_valid_d;
    logic             upd_taken_q, upd_taken_d;
    logic             flush_q, flush_d;
    logic [XLEN-1:0]  redirect_q, redirect_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic             res_error_q, res_error_d;

    assign push_entry = {pred_taken, pred_pc, pred_target};
    assign pred_ready = !q_full;
    assign do_pop     = res_valid && !q_empty;
    // Target only matters when the branch was actually taken.
    assign mis        = do_pop && ((head.taken != res_taken) ||
                                   (res_taken && (head.target != res_target)));
    // Fetch is still on the wrong path this cycle and the next.
    assign drop       = mis || flush_q;
    assign do_push    = pred_valid && !q_full && !drop;

    branch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .push_i      (do_push),
        .push_data_i (push_entry),
        .pop_i       (do_pop),
        .clear_i     (mis),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .head_o      (head)
    );

    // Next-state for the one-cycle pulses, redirect, counters and sticky error.
    always_comb begin
        upd_valid_d  = do_pop;
        upd_taken_d  = do_pop && res_taken;
        flush_d      = mis;
        redirect_d   = '0;
        branch_cnt_d = branch_cnt_q;
        mis_cnt_d    = mis_cnt_q;
        res_error_d  = res_error_q || (res_valid && q_empty);
        if (mis) begin
            redirect_d = res_taken ? res_target : head.pc + PC_STEP;
            mis_cnt_d  = CNT_W'(sat_inc(64'(mis_cnt_q), CNT_W));
        end
        if (do_pop) begin
            branch_cnt_d = CNT_W'(sat_inc(64'(branch_cnt_q), CNT_W));
        end
    end

    // Output and statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upd_valid_q  <= 1'b0;
            upd_taken_q  <= 1'b0;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
            branch_cnt_q <= '0;
            mis_cnt_q    <= '0;
            res_error_q  <= 1'b0;
        end else begin
            upd_valid_q  <= upd_valid_d;
            upd_taken_q  <= upd_taken_d;
            flush_q      <= flush_d;
            redirect_q   <= redirect_d;
            branch_cnt_q <= branch_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
            res_error_q  <= res_error_d;
        end
    end

    assign upd_valid        = upd_valid_q;
    assign upd_taken        = upd_taken_q;
    assign flush            = flush_q;
    assign redirect_pc      = redirect_q;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mis_cnt_q;
    assign res_error        = res_error_q;

endmodule
